// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU-side memory controller.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DREQ  = 2'd1,
    IREQ  = 2'd2,
    DRESP = 2'd3
  } mem_state_t;

  localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;
  localparam int          DEF_BUS_TIMEOUT  = 64;
  localparam logic [31:0] DEF_ERR_DATA     = 32'hDEAD_BEEF;

  function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
    return (a & WORD_MASK) == (b & WORD_MASK);
  endfunction

endpackage

// File: rtl/cpu_mem_timeout.sv
// Bus wait timer: counts cycles since the last clear, flags the final allowed cycle.
module cpu_mem_timeout
  import cpu_mem_pkg::*;
#(
  parameter int BUS_TIMEOUT = DEF_BUS_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int              CW   = $clog2(BUS_TIMEOUT);
  localparam logic [CW-1:0]   LAST = CW'(BUS_TIMEOUT - 1);

  logic [CW-1:0] tcnt_q;

  // Saturates at LAST so a stalled enable never wraps back into range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q <= '0;
    end else if (clear) begin
      tcnt_q <= '0;
    end else if (enable && !expired) begin
      tcnt_q <= tcnt_q + CW'(1);
    end
  end

  assign expired = (tcnt_q == LAST);

endmodule

// File: rtl/cpu_mem_ctrl.sv
// Arbitrates CPU fetches and loads/stores onto one req/ack bus, with a
// one-entry instruction buffer so a repeated fetch word costs no bus cycle.
module cpu_mem_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int          BUS_TIMEOUT = DEF_BUS_TIMEOUT,
  parameter logic [31:0] ERR_DATA    = DEF_ERR_DATA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_data,
  output logic        instr_valid,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr_data,
  input  logic        data_wr,
  input  logic        data_rd,
  output logic [31:0] data_rd_data,
  output logic        data_valid,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err
);

  mem_state_t  state_q;
  logic        bus_req_q, bus_we_q, data_valid_q, bus_err_q, ibuf_vld_q;
  logic [31:0] bus_addr_q, bus_wdata_q, data_rd_data_q, instr_data_q, ibuf_addr_q;
  logic        tmo_clear, tmo_en, tmo_expired;

  assign tmo_clear = (state_q == IDLE) || (state_q == DRESP);
  assign tmo_en    = (state_q == DREQ) || (state_q == IREQ);

  cpu_mem_timeout #(.BUS_TIMEOUT(BUS_TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmo_clear),
    .enable  (tmo_en),
    .expired (tmo_expired)
  );

  assign instr_valid = ibuf_vld_q && same_word(ibuf_addr_q, instr_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      bus_req_q      <= 1'b0;
      bus_we_q       <= 1'b0;
      bus_addr_q     <= '0;
      bus_wdata_q    <= '0;
      data_rd_data_q <= '0;
      data_valid_q   <= 1'b0;
      bus_err_q      <= 1'b0;
      instr_data_q   <= '0;
      ibuf_vld_q     <= 1'b0;
      ibuf_addr_q    <= '0;
    end else begin
      data_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (data_wr || data_rd) begin
            state_q     <= DREQ;
            bus_req_q   <= 1'b1;
            bus_we_q    <= data_wr;
            bus_addr_q  <= data_addr & WORD_MASK;
            bus_wdata_q <= data_wr_data;
          end else if (!instr_valid) begin
            // The buffer is invalid until this fetch returns, so a stale word never hits.
            state_q     <= IREQ;
            bus_req_q   <= 1'b1;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= instr_addr & WORD_MASK;
            ibuf_addr_q <= instr_addr & WORD_MASK;
            ibuf_vld_q  <= 1'b0;
          end
        end
        DREQ: begin
          if (bus_ack) begin
            state_q      <= DRESP;
            bus_req_q    <= 1'b0;
            data_valid_q <= 1'b1;
            if (!bus_we_q) begin
              data_rd_data_q <= bus_rdata;
            end else if (same_word(bus_addr_q, ibuf_addr_q)) begin
              ibuf_vld_q <= 1'b0;
            end
          end else if (tmo_expired) begin
            state_q        <= DRESP;
            bus_req_q      <= 1'b0;
            bus_err_q      <= 1'b1;
            data_rd_data_q <= ERR_DATA;
            data_valid_q   <= 1'b1;
          end
        end
        IREQ: begin
          if (bus_ack) begin
            state_q      <= IDLE;
            bus_req_q    <= 1'b0;
            instr_data_q <= bus_rdata;
            ibuf_vld_q   <= 1'b1;
          end else if (tmo_expired) begin
            // Timed-out fetch hands the core a NOP rather than stalling it forever.
            state_q      <= IDLE;
            bus_req_q    <= 1'b0;
            bus_err_q    <= 1'b1;
            instr_data_q <= '0;
            ibuf_vld_q   <= 1'b1;
          end
        end
        DRESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus_req      = bus_req_q;
  assign bus_we       = bus_we_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wdata    = bus_wdata_q;
  assign data_rd_data = data_rd_data_q;
  assign data_valid   = data_valid_q;
  assign bus_err      = bus_err_q;
  assign instr_data   = instr_data_q;

endmodule

// File: tb/tb_cpu_mem_ctrl.sv
// Directed bench for cpu_mem_ctrl with a small req/ack bus responder.
module tb_cpu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_addr, instr_data;
  logic        instr_valid;
  logic [31:0] data_addr, data_wr_data, data_rd_data;
  logic        data_wr, data_rd, data_valid;
  logic        bus_req, bus_we, bus_ack, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int n_chk = 0;
  int n_bad = 0;

  // responder controls and transaction log
  logic  ack_en   = 1'b1;
  int    ack_wait = 0;
  int    wcnt     = 0;
  logic        log_we[$];
  logic [31:0] log_addr[$];
  logic [31:0] log_wdata[$];

  cpu_mem_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_addr   (instr_addr),
    .instr_data   (instr_data),
    .instr_valid  (instr_valid),
    .data_addr    (data_addr),
    .data_wr_data (data_wr_data),
    .data_wr      (data_wr),
    .data_rd      (data_rd),
    .data_rd_data (data_rd_data),
    .data_valid   (data_valid),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_ack      (bus_ack),
    .bus_err      (bus_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0000_0104: return 32'h1234_5678;
      32'h0000_0040: return 32'hA5A5_A5A5;
      default:       return {a[15:0], 16'hC0DE};
    endcase
  endfunction

  initial begin
    bus_ack   = 1'b0;
    bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus_req) begin
        if (ack_en && wcnt == ack_wait) begin
          bus_ack   = 1'b1;
          bus_rdata = mem_rd(bus_addr);
          log_we.push_back(bus_we);
          log_addr.push_back(bus_addr);
          log_wdata.push_back(bus_wdata);
        end else begin
          bus_ack = 1'b0;
        end
        wcnt++;
      end else begin
        bus_ack = 1'b0;
        wcnt    = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_dv(input string tag);
    for (int i = 0; i < 100 && !data_valid; i++) tick();
    chk(tag, {31'd0, data_valid}, 32'd1);
  endtask

  task automatic wait_iv(input string tag);
    for (int i = 0; i < 100 && !instr_valid; i++) tick();
    chk(tag, {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic clear_log();
    log_we.delete();
    log_addr.delete();
    log_wdata.delete();
  endtask

  initial begin
    int n;
    int dv_cnt;
    rst_n        = 1'b0;
    instr_addr   = 32'h0000_1000;
    data_addr    = '0;
    data_wr_data = '0;
    data_wr      = 1'b0;
    data_rd      = 1'b0;
    tick();
    tick();
    chk("rst_req",    {31'd0, bus_req},     32'd0);
    chk("rst_iv",     {31'd0, instr_valid}, 32'd0);
    chk("rst_dv",     {31'd0, data_valid},  32'd0);
    chk("rst_err",    {31'd0, bus_err},     32'd0);
    chk("rst_addr",   bus_addr,             32'd0);
    chk("rst_rddata", data_rd_data,         32'd0);
    chk("rst_idata",  instr_data,           32'd0);
    rst_n = 1'b1;

    // initial fetch fills the buffer
    wait_iv("boot_iv");
    chk("boot_idata", instr_data, 32'h1000_C0DE);

    // zero-wait read
    tick();
    data_rd   = 1'b1;
    data_addr = 32'h0000_0104;
    tick();
    chk("rd_req",  {31'd0, bus_req},    32'd1);
    chk("rd_addr", bus_addr,            32'h0000_0104);
    chk("rd_we",   {31'd0, bus_we},     32'd0);
    chk("rd_dv0",  {31'd0, data_valid}, 32'd0);
    tick();
    chk("rd_dv1",   {31'd0, data_valid}, 32'd1);
    chk("rd_data",  data_rd_data,        32'h1234_5678);
    chk("rd_reqlo", {31'd0, bus_req},    32'd0);
    data_rd = 1'b0;
    tick();
    chk("rd_dv2", {31'd0, data_valid}, 32'd0);

    // collision: store wins over fetch miss
    clear_log();
    instr_addr   = 32'h0000_0040;
    data_wr      = 1'b1;
    data_addr    = 32'h0000_0200;
    data_wr_data = 32'h1111_2222;
    wait_dv("col_dv");
    data_wr = 1'b0;
    wait_iv("col_iv");
    chk("col_n",    log_we.size(), 32'd2);
    if (log_we.size() == 2) begin
      chk("col_we0",   {31'd0, log_we[0]}, 32'd1);
      chk("col_addr0", log_addr[0],        32'h0000_0200);
      chk("col_wd0",   log_wdata[0],       32'h1111_2222);
      chk("col_we1",   {31'd0, log_we[1]}, 32'd0);
      chk("col_addr1", log_addr[1],        32'h0000_0040);
    end
    chk("col_idata", instr_data, 32'hA5A5_A5A5);

    // buffer hit: no traffic, byte offset ignored
    clear_log();
    for (int i = 0; i < 10; i++) tick();
    chk("hit_n", log_we.size(), 32'd0);
    instr_addr = 32'h0000_0043;
    #1;
    chk("hit_iv", {31'd0, instr_valid}, 32'd1);
    tick();

    // store to same word invalidates and forces a refetch
    data_wr      = 1'b1;
    data_addr    = 32'h0000_0042;
    data_wr_data = 32'h5555_AAAA;
    wait_dv("inv_dv");
    chk("inv_iv", {31'd0, instr_valid}, 32'd0);
    data_wr = 1'b0;
    wait_iv("inv_refetch");
    chk("inv_n", log_we.size(), 32'd2);
    if (log_we.size() == 2) begin
      chk("inv_addr0", log_addr[0],        32'h0000_0040);
      chk("inv_we1",   {31'd0, log_we[1]}, 32'd0);
      chk("inv_addr1", log_addr[1],        32'h0000_0040);
    end

    // read timeout
    ack_en    = 1'b0;
    data_rd   = 1'b1;
    data_addr = 32'h0000_0300;
    tick();
    n = 0;
    while (bus_req && n < 200) begin
      n++;
      tick();
    end
    chk("tmo_len",  n,                   32'd64);
    chk("tmo_dv",   {31'd0, data_valid}, 32'd1);
    chk("tmo_data", data_rd_data,        32'hDEAD_BEEF);
    chk("tmo_err",  {31'd0, bus_err},    32'd1);
    data_rd = 1'b0;
    ack_en  = 1'b1;
    tick();
    tick();
    chk("tmo_sticky", {31'd0, bus_err}, 32'd1);

    // wait-state write: bus fields stable, one completion
    clear_log();
    ack_wait     = 5;
    data_wr      = 1'b1;
    data_addr    = 32'h0000_0504;
    data_wr_data = 32'hCAFE_F00D;
    tick();
    n = 0;
    while (bus_req && n < 20) begin
      chk("ws_addr",  bus_addr,        32'h0000_0504);
      chk("ws_wdata", bus_wdata,       32'hCAFE_F00D);
      chk("ws_we",    {31'd0, bus_we}, 32'd1);
      n++;
      tick();
    end
    chk("ws_len", n, 32'd6);
    dv_cnt = data_valid ? 1 : 0;
    data_wr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (data_valid) dv_cnt++;
    end
    chk("ws_dvcnt", dv_cnt,        32'd1);
    chk("ws_n",     log_we.size(), 32'd1);
    ack_wait = 0;

    // reset in the middle of a fetch
    ack_en     = 1'b0;
    instr_addr = 32'h0000_0800;
    tick();
    chk("rstm_req", {31'd0, bus_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstm_reqlo", {31'd0, bus_req},     32'd0);
    chk("rstm_iv",    {31'd0, instr_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    chk("rstm_idle", {31'd0, bus_req}, 32'd0);
    ack_en = 1'b1;
    wait_iv("rstm_iv2");
    chk("rstm_idata", instr_data,       32'h0800_C0DE);
    chk("rstm_err",   {31'd0, bus_err}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
